uart_rx: RTL and testbench

UART receiver (8N1, LSB first) for the single-core PicoRV32 SoC. It is the receive counterpart of the existing `uart` transmitter and shares its 12 MHz clock domain. It oversamples the asynchronous `uart_rx` pin, reconstructs bytes, and buffers them behind a valid/ack handshake that the memory-mapped I/O decoder serves at address region `4'h2`. It reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 78 +++++++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encodings, default bit period and
// buffer sizing helper used by uart_rx and uart_rx_fifo.
package uart_rx_pkg;

   localparam int UART_RX_DEFAULT_CLKS_PER_BIT = 104;
   localparam int UART_RX_DEFAULT_FIFO_DEPTH   = 4;

   typedef enum logic [1:0] {
      UART_RX_IDLE  = 2'd0,
      UART_RX_START = 2'd1,
      UART_RX_DATA  = 2'd2,
      UART_RX_STOP  = 2'd3
   } uart_rx_state_e;

   // Without the FIFO the buffer collapses to a single holding register.
   function automatic int uart_rx_buf_depth(input int fifo_depth, input bit fifo_en);
      int depth_v;
      if (fifo_en) begin
         depth_v = fifo_depth;
      end else begin
         depth_v = 1;
      end
      return depth_v;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for uart_rx: show-ahead circular FIFO, or a single holding
// register when DEPTH is 1. Same-cycle push and pop both take effect.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       clk12MHz,
   input  logic       resetn,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop_req,
   output logic [7:0] head,
   output logic       not_empty,
   output logic       full,
   output logic       overrun
);

   logic pop_s;
   logic push_ok_s;

   assign pop_s     = pop_req & not_empty;
   assign push_ok_s = push & (~full | pop_s);
   assign overrun   = push & full & ~pop_s;

   if (DEPTH == 1) begin : g_hold
      logic [7:0] data_r;
      logic       valid_r;

      // Holding register: a new byte replaces a popped one in the same cycle.
      always_ff @(posedge clk12MHz or negedge resetn) begin
         if (!resetn) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
         end else if (push_ok_s) begin
            data_r  <= push_data;
            valid_r <= 1'b1;
         end else if (pop_s) begin
            valid_r <= 1'b0;
         end
      end

      assign head      = data_r;
      assign not_empty = valid_r;
      assign full      = valid_r;
   end else begin : g_ring
      localparam int AW = $clog2(DEPTH);

      logic [AW:0] wr_ptr_r;
      logic [AW:0] rd_ptr_r;
      logic [7:0]  mem_r [DEPTH];

      // Ring storage; the extra pointer bit separates full from empty.
      always_ff @(posedge clk12MHz or negedge resetn) begin
         if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               mem_r[i] <= 8'h00;
            end
         end else begin
            if (push_ok_s) begin
               mem_r[wr_ptr_r[AW-1:0]] <= push_data;
               wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
         end
      end

      assign not_empty = (wr_ptr_r != rd_ptr_r);
      assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      assign head      = mem_r[rd_ptr_r[AW-1:0]];
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with valid/ack receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise one holding register.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_RX_DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = UART_RX_DEFAULT_FIFO_DEPTH
) (
   input  logic       clk12MHz,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] recvData,
   output logic       recvValid,
   input  logic       recvAck,
   output logic       frameErr,
   output logic       overrun
);

`ifdef UART_RX_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif

   localparam int BUF_DEPTH = uart_rx_buf_depth(FIFO_DEPTH, FIFO_EN);
   localparam int CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   logic           rx_meta_r;
   logic           rx_sync_r;
   uart_rx_state_e state_r;
   logic [CW-1:0]  cyc_cnt_r;
   logic [2:0]     bit_cnt_r;
   logic [7:0]     shift_r;
   logic [7:0]     byte_r;
   logic           push_r;
   logic           frame_err_r;
   logic           buf_full_s;

   // Two-flop synchronizer for the asynchronous line, idling high.
   always_ff @(posedge clk12MHz or negedge resetn) begin
      if (!resetn) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Frame FSM: samples each bit at its centre and hands good bytes to the buffer.
   always_ff @(posedge clk12MHz or negedge resetn) begin
      if (!resetn) begin
         state_r     <= UART_RX_IDLE;
         cyc_cnt_r   <= '0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         byte_r      <= 8'h00;
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            UART_RX_IDLE: begin
               cyc_cnt_r <= '0;
               bit_cnt_r <= 3'd0;
               if (!rx_sync_r) begin
                  state_r <= UART_RX_START;
               end
            end
            UART_RX_START: begin
               if (cyc_cnt_r == HALF_LAST) begin
                  cyc_cnt_r <= '0;
                  // A start bit that is high again at mid-bit is a glitch.
                  if (!rx_sync_r) begin
                     state_r <= UART_RX_DATA;
                  end else begin
                     state_r <= UART_RX_IDLE;
                  end
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + CW'(1);
               end
            end
            UART_RX_DATA: begin
               if (cyc_cnt_r == BIT_LAST) begin
                  cyc_cnt_r <= '0;
                  shift_r   <= {rx_sync_r, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= UART_RX_STOP;
                  end
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + CW'(1);
               end
            end
            UART_RX_STOP: begin
               if (cyc_cnt_r == BIT_LAST) begin
                  // Leaving at mid-stop leaves room to catch a back-to-back start edge.
                  cyc_cnt_r <= '0;
                  state_r   <= UART_RX_IDLE;
                  if (rx_sync_r) begin
                     push_r <= 1'b1;
                     byte_r <= shift_r;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + CW'(1);
               end
            end
            default: begin
               state_r   <= UART_RX_IDLE;
               cyc_cnt_r <= '0;
            end
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clk12MHz (clk12MHz),
      .resetn   (resetn),
      .push     (push_r),
      .push_data(byte_r),
      .pop_req  (recvAck),
      .head     (recvData),
      .not_empty(recvValid),
      .full     (buf_full_s),
      .overrun  (overrun)
   );

   assign frameErr = frame_err_r;

   logic unused_s;
   assign unused_s = buf_full_s;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared against a byte-queue model of the receive buffer.
module tb_uart_rx;

   localparam int CPB        = 32;
   localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_FIFO_EN
   localparam int CAP = FIFO_DEPTH;
`else
   localparam int CAP = 1;
`endif
   // Stop bit is sampled this many cycles after the start bit is driven.
   localparam int K = 3 + CPB / 2 + 9 * CPB;

   logic       clk12MHz = 1'b0;
   logic       resetn;
   logic       rx;
   logic [7:0] recvData;
   logic       recvValid;
   logic       recvAck;
   logic       frameErr;
   logic       overrun;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] mdl_q[$];

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk12MHz (clk12MHz),
      .resetn   (resetn),
      .rx       (rx),
      .recvData (recvData),
      .recvValid(recvValid),
      .recvAck  (recvAck),
      .frameErr (frameErr),
      .overrun  (overrun)
   );

   always #5 clk12MHz = ~clk12MHz;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_buf(input string tag);
      chk_eq({tag, "_valid"}, {31'd0, recvValid}, {31'd0, mdl_q.size() > 0});
      if (mdl_q.size() > 0) begin
         chk_eq({tag, "_data"}, {24'd0, recvData}, {24'd0, mdl_q[0]});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk12MHz);
         #1;
         rx      = 1'b1;
         recvAck = 1'b0;
      end
   endtask

   task automatic pop_one();
      @(negedge clk12MHz);
      chk_buf("pre_pop");
      @(posedge clk12MHz);
      #1 recvAck = 1'b1;
      @(posedge clk12MHz);
      #1 recvAck = 1'b0;
      if (mdl_q.size() > 0) begin
         void'(mdl_q.pop_front());
      end
      @(negedge clk12MHz);
      chk_buf("post_pop");
   endtask

   // One full frame; optionally acks in the cycle the byte enters the buffer.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit ack_at_push);
      logic [9:0] frame;
      logic       do_pop;
      logic       exp_ov;
      frame = {stop_bit, d, 1'b0};
      for (int c = 0; c < 10 * CPB; c++) begin
         @(posedge clk12MHz);
         #1;
         rx      = frame[c / CPB];
         recvAck = (c == K) ? ack_at_push : 1'b0;
         @(negedge clk12MHz);
         if (c == K - 1) begin
            chk_eq("fe_before", {31'd0, frameErr}, 32'd0);
            chk_eq("ov_before", {31'd0, overrun}, 32'd0);
         end else if (c == K) begin
            do_pop = ack_at_push && (mdl_q.size() > 0);
            exp_ov = stop_bit && (mdl_q.size() == CAP) && !do_pop;
            chk_eq("fe_pulse", {31'd0, frameErr}, {31'd0, ~stop_bit});
            chk_eq("ov_pulse", {31'd0, overrun}, {31'd0, exp_ov});
            chk_buf("pre_push");
            if (do_pop) begin
               void'(mdl_q.pop_front());
            end
            if (stop_bit && (mdl_q.size() < CAP)) begin
               mdl_q.push_back(d);
            end
         end else if (c == K + 1) begin
            chk_eq("fe_after", {31'd0, frameErr}, 32'd0);
            chk_eq("ov_after", {31'd0, overrun}, 32'd0);
            chk_buf("post_push");
         end
      end
   endtask

   initial begin
      bit         fe_seen;
      bit         vld_seen;
      logic [7:0] d;
      logic       stop_bit;
      int         gap;

      resetn  = 1'b0;
      rx      = 1'b1;
      recvAck = 1'b0;
      repeat (3) @(posedge clk12MHz);
      @(negedge clk12MHz);
      chk_eq("rst_valid", {31'd0, recvValid}, 32'd0);
      chk_eq("rst_data", {24'd0, recvData}, 32'd0);
      chk_eq("rst_fe", {31'd0, frameErr}, 32'd0);
      chk_eq("rst_ov", {31'd0, overrun}, 32'd0);
      @(posedge clk12MHz);
      #1 resetn = 1'b1;
      idle(4);

      // Nominal byte, then ack empties the buffer.
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(8);
      pop_one();

      // Short low glitch on the idle line.
      for (int c = 0; c < 10; c++) begin
         @(posedge clk12MHz);
         #1 rx = 1'b0;
      end
      fe_seen  = 1'b0;
      vld_seen = 1'b0;
      for (int c = 0; c < CPB / 2 + 40; c++) begin
         @(posedge clk12MHz);
         #1 rx = 1'b1;
         @(negedge clk12MHz);
         fe_seen  = fe_seen | frameErr;
         vld_seen = vld_seen | recvValid;
      end
      chk_eq("glitch_fe", {31'd0, fe_seen}, 32'd0);
      chk_eq("glitch_valid", {31'd0, vld_seen}, 32'd0);

      // Framing error followed by a good byte.
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(CPB + 8);
      send_frame(8'h55, 1'b1, 1'b0);
      idle(4);
      pop_one();

      // Overrun once the buffer is full; the oldest bytes are kept.
      for (int i = 1; i <= CAP + 1; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
      end
      idle(4);
      for (int i = 0; i <= CAP; i++) begin
         pop_one();
      end

      // Full buffer with ack in the push cycle: no overrun, byte appended.
      for (int i = 0; i < CAP; i++) begin
         send_frame(8'h80 + 8'(i), 1'b1, 1'b0);
      end
      send_frame(8'hC7, 1'b1, 1'b1);
      idle(4);
      for (int i = 0; i <= CAP; i++) begin
         pop_one();
      end

      // Reset in the middle of an 8'hFF frame.
      send_frame(8'h77, 1'b1, 1'b0);
      for (int c = 0; c < 5 * CPB; c++) begin
         @(posedge clk12MHz);
         #1 rx = (c < CPB) ? 1'b0 : 1'b1;
      end
      resetn = 1'b0;
      #2;
      chk_eq("mid_rst_valid", {31'd0, recvValid}, 32'd0);
      chk_eq("mid_rst_data", {24'd0, recvData}, 32'd0);
      chk_eq("mid_rst_fe", {31'd0, frameErr}, 32'd0);
      chk_eq("mid_rst_ov", {31'd0, overrun}, 32'd0);
      mdl_q.delete();
      repeat (3) @(posedge clk12MHz);
      #1 resetn = 1'b1;
      idle(4);
      send_frame(8'h12, 1'b1, 1'b0);
      idle(4);
      pop_one();
      pop_one();

      // Randomized frames, gaps, bad stop bits and acks.
      for (int n = 0; n < 30; n++) begin
         d        = 8'($urandom_range(0, 255));
         stop_bit = ($urandom_range(0, 5) != 0);
         send_frame(d, stop_bit, $urandom_range(0, 3) == 0);
         if (!stop_bit) begin
            gap = CPB + $urandom_range(0, 8);
         end else if ($urandom_range(0, 2) == 0) begin
            gap = 0;
         end else begin
            gap = $urandom_range(1, CPB);
         end
         idle(gap);
         if (gap > 0) begin
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
               pop_one();
            end
         end
      end
      idle(4);
      for (int i = 0; i <= CAP; i++) begin
         pop_one();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
